// File: rtl/icache_pkg.sv
// Shared constants and FSM encoding for the direct-mapped instruction cache.
package icache_pkg;

  localparam int DATA_WIDTH         = 32;
  localparam int ICACHE_INDEX_WIDTH = 8;

  localparam logic                  TRUE      = 1'b1;
  localparam logic                  FALSE     = 1'b0;
  localparam logic [DATA_WIDTH-1:0] ZERO_DATA = '0;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_MEM     = 2'd1,
    WAIT_DISCARD = 2'd2
  } icache_state_e;

endpackage

// File: rtl/icache.sv
// Direct-mapped icache: hit returns in 1 cycle, miss in memory latency + 1; rdy low freezes everything.
// Optional hit/miss counters under ICACHE_STATS_EN.
module icache
  import icache_pkg::*;
#(
  parameter int INDEX_WIDTH = ICACHE_INDEX_WIDTH,
  parameter int ENTRY_NUM   = 2 ** INDEX_WIDTH,
  parameter int TAG_WIDTH   = 32 - INDEX_WIDTH - 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  in_fetch_ce,
  input  logic [31:0]           in_fetch_pc,
  output logic                  out_fetch_ce,
  output logic [DATA_WIDTH-1:0] out_fetch_instr,
  output logic                  out_mem_ce,
  output logic [31:0]           out_mem_pc,
  input  logic                  in_mem_ce,
  input  logic [DATA_WIDTH-1:0] in_mem_instr,
  input  logic                  in_rob_misbranch
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]           out_hit_cnt,
  output logic [31:0]           out_miss_cnt
`endif
);

  logic [ENTRY_NUM-1:0]  valid_q;
  logic [TAG_WIDTH-1:0]  tag_q  [ENTRY_NUM];
  logic [DATA_WIDTH-1:0] data_q [ENTRY_NUM];

  icache_state_e         state_q, state_d;
  logic                  fetch_ce_q, fetch_ce_d;
  logic [DATA_WIDTH-1:0] fetch_instr_q, fetch_instr_d;
  logic                  mem_ce_q, mem_ce_d;
  logic [31:0]           mem_pc_q, mem_pc_d;

  logic [INDEX_WIDTH-1:0] fetch_idx, miss_idx;
  logic [TAG_WIDTH-1:0]   fetch_tag, miss_tag;
  logic                   fetch_acc, fetch_hit, line_wr;
  logic [1:0]             unused_pc_lsb;

  assign fetch_idx     = in_fetch_pc[INDEX_WIDTH+1:2];
  assign fetch_tag     = in_fetch_pc[31:INDEX_WIDTH+2];
  assign miss_idx      = mem_pc_q[INDEX_WIDTH+1:2];
  assign miss_tag      = mem_pc_q[31:INDEX_WIDTH+2];
  assign unused_pc_lsb = in_fetch_pc[1:0];

  // A misbranch in IDLE kills a same-cycle request outright.
  assign fetch_acc = (state_q == IDLE) && in_fetch_ce && !in_rob_misbranch;
  assign fetch_hit = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);

  always_comb begin
    state_d       = state_q;
    fetch_ce_d    = FALSE;
    fetch_instr_d = fetch_instr_q;
    mem_ce_d      = FALSE;
    mem_pc_d      = mem_pc_q;
    line_wr       = FALSE;
    case (state_q)
      IDLE: begin
        if (fetch_acc) begin
          if (fetch_hit) begin
            fetch_ce_d    = TRUE;
            fetch_instr_d = data_q[fetch_idx];
          end else begin
            mem_ce_d = TRUE;
            mem_pc_d = in_fetch_pc;
            state_d  = WAIT_MEM;
          end
        end
      end
      WAIT_MEM: begin
        if (in_mem_ce) begin
          line_wr = TRUE;
          state_d = IDLE;
          if (!in_rob_misbranch) begin
            fetch_ce_d    = TRUE;
            fetch_instr_d = in_mem_instr;
          end
        end else if (in_rob_misbranch) begin
          state_d = WAIT_DISCARD;
        end
      end
      WAIT_DISCARD: begin
        // The response is still correct for its address, so keep it.
        if (in_mem_ce) begin
          line_wr = TRUE;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      valid_q       <= '0;
      fetch_ce_q    <= FALSE;
      fetch_instr_q <= ZERO_DATA;
      mem_ce_q      <= FALSE;
      mem_pc_q      <= '0;
    end else if (rdy) begin
      state_q       <= state_d;
      fetch_ce_q    <= fetch_ce_d;
      fetch_instr_q <= fetch_instr_d;
      mem_ce_q      <= mem_ce_d;
      mem_pc_q      <= mem_pc_d;
      if (line_wr) valid_q[miss_idx] <= TRUE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && rdy && line_wr) begin
      tag_q[miss_idx]  <= miss_tag;
      data_q[miss_idx] <= in_mem_instr;
    end
  end

  assign out_fetch_ce    = fetch_ce_q;
  assign out_fetch_instr = fetch_instr_q;
  assign out_mem_ce      = mem_ce_q;
  assign out_mem_pc      = mem_pc_q;

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (rdy && fetch_acc) begin
      if (fetch_hit) hit_cnt_q  <= hit_cnt_q + 32'd1;
      else           miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign out_hit_cnt  = hit_cnt_q;
  assign out_miss_cnt = miss_cnt_q;
`else
  // No statistics counters in this build.
`endif

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: cold miss, hit, conflict, misbranch cases, rdy stall, reset mid-miss.
module tb_icache;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        in_fetch_ce;
  logic [31:0] in_fetch_pc;
  logic        out_fetch_ce;
  logic [31:0] out_fetch_instr;
  logic        out_mem_ce;
  logic [31:0] out_mem_pc;
  logic        in_mem_ce;
  logic [31:0] in_mem_instr;
  logic        in_rob_misbranch;
`ifdef ICACHE_STATS_EN
  logic [31:0] out_hit_cnt, out_miss_cnt;
`endif

  int total = 0;
  int bad   = 0;

  icache dut (
    .clk              (clk),
    .rst              (rst),
    .rdy              (rdy),
    .in_fetch_ce      (in_fetch_ce),
    .in_fetch_pc      (in_fetch_pc),
    .out_fetch_ce     (out_fetch_ce),
    .out_fetch_instr  (out_fetch_instr),
    .out_mem_ce       (out_mem_ce),
    .out_mem_pc       (out_mem_pc),
    .in_mem_ce        (in_mem_ce),
    .in_mem_instr     (in_mem_instr),
    .in_rob_misbranch (in_rob_misbranch)
`ifdef ICACHE_STATS_EN
    ,
    .out_hit_cnt      (out_hit_cnt),
    .out_miss_cnt     (out_miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] pc);
    in_fetch_ce = 1'b1;
    in_fetch_pc = pc;
    tick();
    in_fetch_ce = 1'b0;
  endtask

  task automatic mem_resp(input logic [31:0] d);
    in_mem_ce    = 1'b1;
    in_mem_instr = d;
    tick();
    in_mem_ce    = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1;
    in_fetch_ce = 1'b0; in_fetch_pc = '0;
    in_mem_ce = 1'b0; in_mem_instr = '0; in_rob_misbranch = 1'b0;
    tick(); tick();
    check("rst_fetch_ce", {31'd0, out_fetch_ce}, 32'd0);
    check("rst_instr",    out_fetch_instr, 32'd0);
    check("rst_mem_ce",   {31'd0, out_mem_ce}, 32'd0);
    check("rst_mem_pc",   out_mem_pc, 32'd0);
    rst = 1'b0;
    tick();

    // Cold miss, memory answers four cycles after the request.
    fetch(32'h0000_0000);
    check("cold_mem_ce",   {31'd0, out_mem_ce}, 32'd1);
    check("cold_mem_pc",   out_mem_pc, 32'h0);
    check("cold_no_fetch", {31'd0, out_fetch_ce}, 32'd0);
    tick();
    check("cold_mem_pulse", {31'd0, out_mem_ce}, 32'd0);
    tick(); tick();
    mem_resp(32'h0000_0513);
    check("cold_fetch_ce", {31'd0, out_fetch_ce}, 32'd1);
    check("cold_instr",    out_fetch_instr, 32'h0000_0513);
    tick();
    check("cold_fetch_pulse", {31'd0, out_fetch_ce}, 32'd0);

    // Hit on the freshly filled line.
    fetch(32'h0000_0000);
    check("hit_fetch_ce", {31'd0, out_fetch_ce}, 32'd1);
    check("hit_instr",    out_fetch_instr, 32'h0000_0513);
    check("hit_no_mem",   {31'd0, out_mem_ce}, 32'd0);

    // 0x400 aliases index 0 with a different tag.
    fetch(32'h0000_0400);
    check("conf_a_mem_ce", {31'd0, out_mem_ce}, 32'd1);
    check("conf_a_mem_pc", out_mem_pc, 32'h0000_0400);
    check("conf_a_no_fetch", {31'd0, out_fetch_ce}, 32'd0);
    tick();
    mem_resp(32'h0010_0093);
    check("conf_a_instr", out_fetch_instr, 32'h0010_0093);
    check("conf_a_ce",    {31'd0, out_fetch_ce}, 32'd1);
    fetch(32'h0000_0000);
    check("conf_b_mem_ce", {31'd0, out_mem_ce}, 32'd1);
    check("conf_b_mem_pc", out_mem_pc, 32'h0);
    check("conf_b_no_fetch", {31'd0, out_fetch_ce}, 32'd0);
    mem_resp(32'h0000_0513);
    check("conf_b_instr", out_fetch_instr, 32'h0000_0513);

    // Misbranch in IDLE drops a same-cycle hit.
    in_rob_misbranch = 1'b1;
    fetch(32'h0000_0000);
    in_rob_misbranch = 1'b0;
    check("mb_idle_fetch", {31'd0, out_fetch_ce}, 32'd0);
    check("mb_idle_mem",   {31'd0, out_mem_ce}, 32'd0);

    // Misbranch mid-miss: response discarded but line kept.
    fetch(32'h0000_0008);
    check("mb_mid_mem_pc", out_mem_pc, 32'h0000_0008);
    tick();
    in_rob_misbranch = 1'b1;
    tick();
    in_rob_misbranch = 1'b0;
    tick();
    mem_resp(32'hDEAD_BEEF);
    check("mb_mid_suppress", {31'd0, out_fetch_ce}, 32'd0);
    tick();
    check("mb_mid_quiet", {31'd0, out_fetch_ce}, 32'd0);
    fetch(32'h0000_0008);
    check("mb_mid_hit_ce", {31'd0, out_fetch_ce}, 32'd1);
    check("mb_mid_hit",    out_fetch_instr, 32'hDEAD_BEEF);
    check("mb_mid_no_mem", {31'd0, out_mem_ce}, 32'd0);

    // Misbranch together with the memory response.
    fetch(32'h0000_000C);
    tick();
    in_rob_misbranch = 1'b1;
    mem_resp(32'h1234_5678);
    in_rob_misbranch = 1'b0;
    check("sim_suppress", {31'd0, out_fetch_ce}, 32'd0);
    fetch(32'h0000_000C);
    check("sim_hit_ce", {31'd0, out_fetch_ce}, 32'd1);
    check("sim_hit",    out_fetch_instr, 32'h1234_5678);

    // Stray memory response in IDLE is ignored.
    mem_resp(32'h5555_5555);
    check("idle_mem_ign", {31'd0, out_fetch_ce}, 32'd0);

    // rdy stall while out_mem_ce is high: outputs freeze, stray response ignored.
    fetch(32'h0000_0044);
    check("stall_mem_ce", {31'd0, out_mem_ce}, 32'd1);
    rdy = 1'b0;
    in_mem_ce = 1'b1; in_mem_instr = 32'hBAD0_BAD0;
    tick(); tick(); tick();
    check("stall_hold_mem_ce", {31'd0, out_mem_ce}, 32'd1);
    check("stall_hold_mem_pc", out_mem_pc, 32'h0000_0044);
    check("stall_no_fetch",    {31'd0, out_fetch_ce}, 32'd0);
    in_mem_ce = 1'b0;
    rdy = 1'b1;
    tick();
    check("stall_resume_mem", {31'd0, out_mem_ce}, 32'd0);
    check("stall_still_wait", {31'd0, out_fetch_ce}, 32'd0);
    mem_resp(32'hCAFE_0001);
    check("stall_done_ce", {31'd0, out_fetch_ce}, 32'd1);
    check("stall_done",    out_fetch_instr, 32'hCAFE_0001);
    fetch(32'h0000_0044);
    check("stall_hit", out_fetch_instr, 32'hCAFE_0001);

    // Reset mid-miss abandons the request and invalidates everything.
    fetch(32'h0000_0020);
    rst = 1'b1;
    tick();
    check("rstm_mem_ce", {31'd0, out_mem_ce}, 32'd0);
    rst = 1'b0;
    mem_resp(32'h7777_7777);
    check("rstm_ignored", {31'd0, out_fetch_ce}, 32'd0);
    fetch(32'h0000_0000);
    check("rstm_cold_mem", {31'd0, out_mem_ce}, 32'd1);
    check("rstm_cold_nofetch", {31'd0, out_fetch_ce}, 32'd0);
    mem_resp(32'h0000_0513);
    check("rstm_refill", out_fetch_instr, 32'h0000_0513);
    fetch(32'h0000_0020);
    check("rstm_stale_miss", {31'd0, out_mem_ce}, 32'd1);
    mem_resp(32'h0000_0020);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/icache.md
Name: icache

Overview:
- Direct-mapped instruction cache between the fetcher and the memory controller.
- Accepts single-cycle fetch requests (pc) from the fetcher.
- On a hit, returns the instruction word one cycle later.
- On a miss, issues a word request to the memory controller, fills the line, then returns the word.
- Absorbs ROB misbranch flushes so a stale memory response never reaches the fetcher.

Parameters:
- INDEX_WIDTH, 8, log2 of line count; one 32-bit instruction per line.
- ENTRY_NUM, 256, line count; must equal 2**INDEX_WIDTH.
- TAG_WIDTH, 22, 32 - INDEX_WIDTH - 2.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- rst  input  1  synchronous active-high reset.
- rdy  input  1  global enable; when low, all state and outputs hold.
- in_fetch_ce  input  1  fetch request pulse.
- in_fetch_pc  input  32  fetch address, word aligned.
- out_fetch_ce  output  1  instruction-valid pulse to fetcher.
- out_fetch_instr  output  32  instruction word.
- out_mem_ce  output  1  memory read request pulse.
- out_mem_pc  output  32  memory read address.
- in_mem_ce  input  1  memory response valid.
- in_mem_instr  input  32  memory response word.
- in_rob_misbranch  input  1  flush.

Behaviour:
- Address split:
  - pc[1:0] ignored.
  - index = pc[INDEX_WIDTH+1:2].
  - tag = pc[31:INDEX_WIDTH+2].
- Storage per line: valid bit, tag, 32-bit data.
- Reset:
  - all valid bits cleared; state IDLE.
  - out_fetch_ce = 0, out_fetch_instr = 0, out_mem_ce = 0, out_mem_pc = 0.
  - Reset mid-miss abandons the request; a later in_mem_ce in IDLE is ignored.
- Pulse outputs: out_fetch_ce and out_mem_ce default to 0 every rdy cycle and are asserted for exactly one cycle.
- State IDLE:
  - in_fetch_ce with a hit (valid and tag match): next cycle out_fetch_ce = 1 and out_fetch_instr = line data. Latency 1; stay IDLE.
  - in_fetch_ce with a miss: latch the pc; next cycle out_mem_ce = 1 and out_mem_pc = pc; go to WAIT_MEM.
- State WAIT_MEM, on in_mem_ce:
  - write the line (data, tag, valid = 1).
  - next cycle out_fetch_ce = 1 and out_fetch_instr = in_mem_instr; go to IDLE.
  - Miss latency is therefore memory latency + 1.
- State WAIT_DISCARD, on in_mem_ce:
  - write the line (the data is correct for that address).
  - no out_fetch_ce; go to IDLE.
- Misbranch (highest priority):
  - In IDLE: drop any same-cycle request; out_fetch_ce = 0 next cycle.
  - In WAIT_MEM without in_mem_ce: go to WAIT_DISCARD.
  - In WAIT_MEM with in_mem_ce in the same cycle: fill the line, suppress the response, go to IDLE.
  - In WAIT_DISCARD: stay.
- in_fetch_ce outside IDLE is ignored; the fetcher never issues one while busy.
- Memory requests are never issued from WAIT_DISCARD.
- in_mem_ce while IDLE is ignored.
- Index wrap: pc 0x0000_0400 and pc 0x0000_0000 share index 0 with ENTRY_NUM = 256; conflict handled by tag mismatch and replacement.

Optional Feature:
- Macro: ICACHE_STATS_EN.
- Defined:
  - adds outputs out_hit_cnt[31:0] and out_miss_cnt[31:0], both reset to 0.
  - hit_cnt increments on each accepted hit; miss_cnt increments on each issued memory request.
  - Requests dropped by misbranch count as neither.
  - Both counters wrap at 2^32.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared constants file (existing constant.v): DATA_WIDTH, TRUE/FALSE, ZERO_DATA, ICACHE_INDEX_WIDTH default.
- Local state encodings IDLE / WAIT_MEM / WAIT_DISCARD.
- No sub-module: the tag/data arrays are plain register arrays inside icache.

Test Plan:
- Cold miss:
  - Stimulus: reset; fetch 0x0000_0000; memory returns 0x0000_0513 four cycles after out_mem_ce.
  - Response: out_mem_ce one cycle after the request with pc 0x0; out_fetch_ce with 0x0000_0513 one cycle after in_mem_ce.
- Hit:
  - Stimulus: fetch 0x0000_0000 again.
  - Response: out_fetch_ce with 0x0000_0513 next cycle; out_mem_ce stays 0.
- Conflict:
  - Stimulus: fetch 0x0000_0400 (same index, new tag), memory returns 0x0010_0093; then fetch 0x0000_0000.
  - Response: both fetches miss; memory traffic for each.
- Misbranch mid-miss:
  - Stimulus: fetch 0x0000_0008 misses; misbranch two cycles later; memory returns 0xDEAD_BEEF.
  - Response: no out_fetch_ce; a following fetch of 0x0000_0008 hits and returns 0xDEAD_BEEF.
- Simultaneous misbranch and in_mem_ce:
  - Response: no response pulse; line filled; state IDLE.
- rdy stall:
  - Stimulus: drop rdy during WAIT_MEM for 3 cycles.
  - Response: state and outputs frozen; completion resumes correctly once rdy returns.
